vga_mode_sequencer: RTL and testbench

Frame-synchronous controller that owns the active screen mode word driven into vga_controller's screenMode input. It accepts mode-change requests from the CPU side through a valid/ready handshake. Each accepted change is applied only at a vertical-sync boundary, so the image-memory address mux never switches mid-frame. An optional brightness fade-out/fade-in sequence wraps each change, and a registered per-channel colour scaler applies that brightness to pixel data.

---
 rtl/vga_mode_sequencer.sv | 157 +++++++++++++++
 tb/tb_vga_mode_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_sequencer.sv
// Frame-synchronous owner of the VGA screen mode word with a brightness scaler.
// Define MODE_SEQ_FADE_EN to wrap each mode change in a fade-out/fade-in sequence.
module vga_mode_sequencer #(
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter logic [31:0] RESET_MODE      = 32'h0000_0000
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iVS,
    input  logic [31:0] req_mode,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [31:0] active_mode,
    output logic        mode_changed,
    output logic        busy,
    output logic [3:0]  fade_level,
    output logic [15:0] frame_count,
    input  logic [23:0] rgb_in,
    output logic [23:0] rgb_out
);

    typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} state_t;

    state_t      state_q, state_d;
    logic [31:0] active_q, active_d;
    logic [31:0] pend_q, pend_d;
    logic        mode_chg_q, mode_chg_d;
    logic [15:0] fc_q, fc_d;
    logic        prev_vs_q;
    logic [23:0] rgb_q, rgb_d;
    logic        tick;
    logic        accept;

`ifdef MODE_SEQ_FADE_EN
    localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
    logic [3:0]  fade_q, fade_d;
    logic [7:0]  step_q, step_d;
    logic [11:0] prod;
`endif

    always_comb begin
        tick       = prev_vs_q & ~iVS;
        accept     = req_valid && (state_q == IDLE);
        state_d    = state_q;
        active_d   = active_q;
        pend_d     = pend_q;
        mode_chg_d = 1'b0;
        fc_d       = fc_q + {15'd0, tick};
`ifdef MODE_SEQ_FADE_EN
        fade_d     = fade_q;
        step_d     = step_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MODE_SEQ_FADE_EN
                fade_d = 4'hF;
`endif
                // A request matching the live mode completes the handshake with no effect.
                if (accept && (req_mode != active_q)) begin
                    pend_d = req_mode;
`ifdef MODE_SEQ_FADE_EN
                    step_d  = '0;
                    state_d = FADE_OUT;
`else
                    state_d = SWAP;
`endif
                end
            end
`ifdef MODE_SEQ_FADE_EN
            FADE_OUT: if (tick) begin
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    fade_d = fade_q - 4'd1;
                    if (fade_q == 4'd1) state_d = SWAP;
                end else begin
                    step_d = step_q + 8'd1;
                end
            end
            FADE_IN: if (tick) begin
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    fade_d = fade_q + 4'd1;
                    if (fade_q == 4'd14) state_d = IDLE;
                end else begin
                    step_d = step_q + 8'd1;
                end
            end
`endif
            SWAP: if (tick) begin
                active_d   = pend_q;
                mode_chg_d = 1'b1;
`ifdef MODE_SEQ_FADE_EN
                step_d     = '0;
                state_d    = FADE_IN;
`else
                state_d    = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-channel brightness scale; full level bypasses the multiply so white stays 8'hFF.
    always_comb begin
        rgb_d = rgb_in;
`ifdef MODE_SEQ_FADE_EN
        prod  = '0;
        if (fade_q != 4'hF) begin
            for (int i = 0; i < 3; i++) begin
                prod             = {4'd0, rgb_in[i*8 +: 8]} * {8'd0, fade_q};
                rgb_d[i*8 +: 8]  = prod[11:4];
            end
        end
`endif
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= IDLE;
            active_q   <= RESET_MODE;
            pend_q     <= '0;
            mode_chg_q <= 1'b0;
            fc_q       <= '0;
            prev_vs_q  <= 1'b1;
            rgb_q      <= '0;
`ifdef MODE_SEQ_FADE_EN
            fade_q     <= 4'hF;
            step_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            mode_chg_q <= mode_chg_d;
            fc_q       <= fc_d;
            prev_vs_q  <= iVS;
            rgb_q      <= rgb_d;
`ifdef MODE_SEQ_FADE_EN
            fade_q     <= fade_d;
            step_q     <= step_d;
`endif
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign active_mode  = active_q;
    assign mode_changed = mode_chg_q;
    assign frame_count  = fc_q;
    assign rgb_out      = rgb_q;
`ifdef MODE_SEQ_FADE_EN
    assign fade_level   = fade_q;
`else
    assign fade_level   = 4'hF;
`endif

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer: directed sequences, a scaler vector
// table and a randomized run against a tick-counting reference model.
module tb_vga_mode_sequencer;
    localparam int F     = 2;
`ifdef MODE_SEQ_FADE_EN
    localparam int SWAPK = 15*F + 1;
    localparam int ENDK  = 30*F + 1;
`else
    localparam int SWAPK = 1;
    localparam int ENDK  = 1;
`endif

    logic        clk = 1'b0, rst_n = 1'b1, vs = 1'b1, req_valid = 1'b0;
    logic        req_ready, mode_changed, busy;
    logic [31:0] req_mode = '0, active_mode;
    logic [3:0]  fade_level;
    logic [15:0] frame_count;
    logic [23:0] rgb_in = '0, rgb_out;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [23:0] rgb;
        logic [23:0] at8;
    } vec_t;
    vec_t tbl[5];

    // Reference model state: acceptance-relative tick count drives everything.
    logic [31:0] m_active, m_pend;
    logic        m_busy, m_prev, m_mc, m_tick;
    int          m_k;
    logic [15:0] m_fc;
    logic [23:0] m_rgb;

    always #5 clk = ~clk;

    vga_mode_sequencer #(.FRAMES_PER_STEP(F), .RESET_MODE(32'h0)) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs),
        .req_mode(req_mode), .req_valid(req_valid), .req_ready(req_ready),
        .active_mode(active_mode), .mode_changed(mode_changed), .busy(busy),
        .fade_level(fade_level), .frame_count(frame_count),
        .rgb_in(rgb_in), .rgb_out(rgb_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        vs = 1'b0; step();
        vs = 1'b1; step();
    endtask

    task automatic run_table(input bit at8);
        for (int i = 0; i < 5; i++) begin
            rgb_in = tbl[i].rgb;
            step();
            chk(at8 ? "rgb_scaled8" : "rgb_pass", 32'(rgb_out), 32'(at8 ? tbl[i].at8 : tbl[i].rgb));
        end
    endtask

    function automatic logic [3:0] m_fade(input logic b, input int k);
`ifdef MODE_SEQ_FADE_EN
        if (!b) return 4'hF;
        if (k <= 15*F) return 4'(15 - k/F);
        return 4'((k - 15*F - 1)/F);
`else
        return 4'hF;
`endif
    endfunction

    function automatic logic [23:0] m_scale(input logic [23:0] c, input logic [3:0] f);
        logic [23:0] r;
        if (f == 4'hF) return c;
        for (int i = 0; i < 3; i++) r[i*8 +: 8] = 8'((int'(c[i*8 +: 8]) * int'(f)) / 16);
        return r;
    endfunction

    initial begin
        tbl[0] = '{24'hFF8040, 24'h7F4020};
        tbl[1] = '{24'h010203, 24'h000101};
        tbl[2] = '{24'h123456, 24'h091A2B};
        tbl[3] = '{24'hFFFFFF, 24'h7F7F7F};
        tbl[4] = '{24'h000000, 24'h000000};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_active", active_mode, 32'h0);
        chk("rst_fade", 32'(fade_level), 32'hF);
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fc", 32'(frame_count), 32'h0);
        chk("rst_mc", 32'(mode_changed), 32'h0);
        chk("rst_rgb", 32'(rgb_out), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("fc_zero", 32'(frame_count), 32'h0);
        repeat (3) tick();
        chk("fc_three", 32'(frame_count), 32'h3);
        run_table(1'b0);

        // Request equal to the live mode is a no-op
        req_mode = 32'h0; req_valid = 1'b1; step(); req_valid = 1'b0;
        chk("noop_busy", 32'(busy), 32'h0);
        chk("noop_mc", 32'(mode_changed), 32'h0);
        step();
        chk("noop_busy2", 32'(busy), 32'h0);
        chk("noop_fade", 32'(fade_level), 32'hF);

`ifdef MODE_SEQ_FADE_EN
        req_mode = 32'h2000_0000; req_valid = 1'b1; step();
        chk("busy_after_accept", 32'(busy), 32'h1);
        req_mode = 32'h4000_0000;  // held while busy, must wait for IDLE
        for (int t = 1; t <= 61; t++) begin
            vs = 1'b0; step();
            if (t < 61) chk("ready_during_fade", 32'(req_ready), 32'h0);
            if (t == 2)  chk("fade_t2", 32'(fade_level), 32'hE);
            if (t == 14) begin
                chk("fade_t14", 32'(fade_level), 32'h8);
                run_table(1'b1);
            end
            if (t == 30) begin
                chk("fade_t30", 32'(fade_level), 32'h0);
                chk("active_t30", active_mode, 32'h0);
            end
            if (t == 31) begin
                chk("active_t31", active_mode, 32'h2000_0000);
                chk("mc_t31", 32'(mode_changed), 32'h1);
            end
            if (t == 61) begin
                chk("fade_t61", 32'(fade_level), 32'hF);
                chk("busy_t61", 32'(busy), 32'h0);
                chk("ready_t61", 32'(req_ready), 32'h1);
            end
            vs = 1'b1; step();
            chk("mc_single", 32'(mode_changed), 32'h0);
            if (t == 61) chk("second_accept", 32'(busy), 32'h1);
        end
        req_valid = 1'b0;
        repeat (45) tick();
        chk("fadein_7", 32'(fade_level), 32'h7);
        chk("active_second", active_mode, 32'h4000_0000);
        rst_n = 1'b0; #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_fade", 32'(fade_level), 32'hF);
        chk("abort_active", active_mode, 32'h0);
        step(); rst_n = 1'b1; step();
        tick();
        chk("abort_discard", active_mode, 32'h0);
`else
        // Tick in the acceptance cycle must not count
        req_mode = 32'h6000_0005; req_valid = 1'b1; vs = 1'b0; step();
        req_valid = 1'b0; vs = 1'b1;
        chk("nf_busy", 32'(busy), 32'h1);
        chk("nf_active_hold", active_mode, 32'h0);
        step();
        chk("nf_busy_acc_tick", 32'(busy), 32'h1);
        vs = 1'b0; step();
        chk("nf_active", active_mode, 32'h6000_0005);
        chk("nf_busy_drop", 32'(busy), 32'h0);
        chk("nf_mc", 32'(mode_changed), 32'h1);
        vs = 1'b1; step();
        chk("nf_mc_off", 32'(mode_changed), 32'h0);
        req_mode = 32'h2000_0000; req_valid = 1'b1; step(); req_valid = 1'b0;
        chk("nf_busy2", 32'(busy), 32'h1);
        rst_n = 1'b0; #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_active", active_mode, 32'h0);
        step(); rst_n = 1'b1; step();
        tick();
        chk("abort_discard", active_mode, 32'h0);
        chk("abort_mc", 32'(mode_changed), 32'h0);
`endif

        // Randomized run against the reference model
        rst_n = 1'b0; vs = 1'b1; req_valid = 1'b0; rgb_in = '0; #1;
        rst_n = 1'b1;
        m_active = 32'h0; m_pend = 32'h0; m_busy = 1'b0; m_prev = 1'b1;
        m_mc = 1'b0; m_k = 0; m_fc = '0; m_rgb = '0;
        for (int c = 0; c < 4000; c++) begin
            vs        = 1'($urandom_range(0, 1));
            req_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       req_mode = 32'h0;
                1:       req_mode = 32'h2000_0000;
                2:       req_mode = 32'h6000_0005;
                default: req_mode = m_active;
            endcase
            rgb_in = 24'($urandom);
            m_tick = m_prev & ~vs;
            m_rgb  = m_scale(rgb_in, m_fade(m_busy, m_k));
            m_fc   = m_fc + 16'(m_tick);
            m_mc   = 1'b0;
            if (!m_busy) begin
                if (req_valid && req_mode != m_active) begin
                    m_busy = 1'b1; m_pend = req_mode; m_k = 0;
                end
            end else if (m_tick) begin
                m_k++;
                if (m_k == SWAPK) begin m_active = m_pend; m_mc = 1'b1; end
                if (m_k == ENDK) m_busy = 1'b0;
            end
            m_prev = vs;
            step();
            chk("r_active", active_mode, m_active);
            chk("r_mc", 32'(mode_changed), 32'(m_mc));
            chk("r_busy", 32'(busy), 32'(m_busy));
            chk("r_ready", 32'(req_ready), 32'(!m_busy));
            chk("r_fade", 32'(fade_level), 32'(m_fade(m_busy, m_k)));
            chk("r_fc", 32'(frame_count), 32'(m_fc));
            chk("r_rgb", 32'(rgb_out), 32'(m_rgb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
